// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the display scan controller.
//   scan_state_e : controller states (IDLE -> GAP -> SHOW -> GAP ...)
//   BCD_W/SEG_W  : widths of a BCD digit and of the segment bus
//   BCD_MAX      : largest valid BCD digit; anything above is blanked
//   SEG_BLANK    : active-low segment pattern with every segment off
package display_scan_ctrl_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned BCD_MAX = 9;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2
    } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Datapath/board-side bundle of the display scan controller.
//   master : datapath side (drives en/load/digits_in/lz_blank)
//   slave  : controller side (drives load_ack/frame_done/an/seg)
interface display_scan_ctrl_if #(
    parameter int unsigned N_DIG = 4
);
    logic                 en;
    logic                 load;
    logic [4*N_DIG-1:0]   digits_in;
    logic                 lz_blank;
    logic                 load_ack;
    logic                 frame_done;
    logic [N_DIG-1:0]     an;
    logic [6:0]           seg;

    modport master (
        output en, load, digits_in, lz_blank,
        input  load_ack, frame_done, an, seg
    );

    modport slave (
        input  en, load, digits_in, lz_blank,
        output load_ack, frame_done, an, seg
    );
endinterface

// File: rtl/display_scan_ctrl_codificador.sv
// BCD -> common-anode 7-segment encoder (l = {g,f,e,d,c,b,a}, active-low).
//   bcd : 4-bit BCD digit
//   l   : segment pattern; non-BCD codes give all segments off
module display_scan_ctrl_codificador
    import display_scan_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] l
);

    always_comb begin
        l = SEG_BLANK;
        case (bcd)
            4'd0: l = 7'h40;
            4'd1: l = 7'h79;
            4'd2: l = 7'h24;
            4'd3: l = 7'h30;
            4'd4: l = 7'h19;
            4'd5: l = 7'h12;
            4'd6: l = 7'h02;
            4'd7: l = 7'h78;
            4'd8: l = 7'h00;
            4'd9: l = 7'h10;
            default: l = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N_DIG-digit common-anode display.
// One shared encoder is fed from a registered mux of the committed (shadow)
// digits; new data is double-buffered and only committed at frame end or idle.
//   clk, rst_n : clock, async active-low reset
//   bus.en/load/digits_in/lz_blank : control and data from the datapath
//   bus.load_ack   : pulse the cycle after loaded data is committed
//   bus.frame_done : pulse during the last cycle of the last digit's slot
//   bus.an         : active-low anode selects (registered)
//   bus.seg        : encoder output for the selected digit
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned N_DIG     = 4,
    parameter int unsigned PRESC     = 1000,
    parameter int unsigned BLANK_GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_scan_ctrl_if.slave   bus
);

    localparam int unsigned DW = BCD_W * N_DIG;
    localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int unsigned PW = $clog2(PRESC + 1);
    localparam int unsigned GW = $clog2(BLANK_GAP + 1);

    scan_state_e      state_q, state_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic [PW-1:0]    pcnt_q, pcnt_n;
    logic [GW-1:0]    gcnt_q, gcnt_n;
    logic [DW-1:0]    shadow_q, shadow_n;
    logic [DW-1:0]    pbuf_q, pbuf_n;
    logic             pend_q, pend_n;
    logic [BCD_W-1:0] bcd_q, bcd_n;
    logic [N_DIG-1:0] an_n;
    logic [N_DIG-1:0] blank;
    logic             ack_n;
    logic             fd_n;
    logic             frame_end;
    logic             commit;
    logic             seen_nz;
    logic [BCD_W-1:0] dig;

    // Next-state, buffering, blanking and output look-ahead
    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        pcnt_n    = pcnt_q;
        gcnt_n    = gcnt_q;
        frame_end = 1'b0;
        shadow_n  = shadow_q;
        pbuf_n    = pbuf_q;
        pend_n    = pend_q;
        ack_n     = 1'b0;
        blank     = '0;
        seen_nz   = 1'b0;
        dig       = '0;
        an_n      = '1;
        bcd_n     = '0;

        if (!bus.en) begin
            state_n = ST_IDLE;
            idx_n   = '0;
            pcnt_n  = '0;
            gcnt_n  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_n = ST_GAP;
                    idx_n   = '0;
                    pcnt_n  = '0;
                    gcnt_n  = '0;
                end
                ST_GAP: begin
                    if (gcnt_q == GW'(BLANK_GAP - 1)) begin
                        state_n = ST_SHOW;
                        gcnt_n  = '0;
                        pcnt_n  = '0;
                    end else begin
                        gcnt_n = gcnt_q + GW'(1);
                    end
                end
                ST_SHOW: begin
                    if (pcnt_q == PW'(PRESC - 1)) begin
                        state_n = ST_GAP;
                        pcnt_n  = '0;
                        if (idx_q == IW'(N_DIG - 1)) begin
                            idx_n     = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_n = idx_q + IW'(1);
                        end
                    end else begin
                        pcnt_n = pcnt_q + PW'(1);
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        // A load landing on a commit cycle bypasses the pending buffer
        commit = (state_q == ST_IDLE) || frame_end;
        if (commit) begin
            if (bus.load) begin
                shadow_n = bus.digits_in;
                pend_n   = 1'b0;
                ack_n    = 1'b1;
            end else if (pend_q) begin
                shadow_n = pbuf_q;
                pend_n   = 1'b0;
                ack_n    = 1'b1;
            end
        end else if (bus.load) begin
            pbuf_n = bus.digits_in;
            pend_n = 1'b1;
        end

        // Invalid digits always dark; leading zeros dark from the top, digit 0 excepted
        for (int k = int'(N_DIG) - 1; k >= 0; k--) begin
            dig = shadow_n[BCD_W*k +: BCD_W];
            if (dig > BCD_W'(BCD_MAX)) begin
                blank[k] = 1'b1;
            end else if (bus.lz_blank && !seen_nz && dig == '0 && k != 0) begin
                blank[k] = 1'b1;
            end
            if (dig != '0) begin
                seen_nz = 1'b1;
            end
        end

        for (int k = 0; k < int'(N_DIG); k++) begin
            if (idx_n == IW'(k)) begin
                bcd_n = shadow_n[BCD_W*k +: BCD_W];
                if (state_n == ST_SHOW && !blank[k]) begin
                    an_n[k] = 1'b0;
                end
            end
        end

        fd_n = (state_n == ST_SHOW) && (idx_n == IW'(N_DIG - 1)) &&
               (pcnt_n == PW'(PRESC - 1));
    end

    // State, counters, buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            pcnt_q         <= '0;
            gcnt_q         <= '0;
            shadow_q       <= '0;
            pbuf_q         <= '0;
            pend_q         <= 1'b0;
            bcd_q          <= '0;
            bus.an         <= '1;
            bus.load_ack   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state_q        <= state_n;
            idx_q          <= idx_n;
            pcnt_q         <= pcnt_n;
            gcnt_q         <= gcnt_n;
            shadow_q       <= shadow_n;
            pbuf_q         <= pbuf_n;
            pend_q         <= pend_n;
            bcd_q          <= bcd_n;
            bus.an         <= an_n;
            bus.load_ack   <= ack_n;
            bus.frame_done <= fd_n;
        end
    end

    display_scan_ctrl_codificador u_enc (
        .bcd (bcd_q),
        .l   (bus.seg)
    );

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with N_DIG=4, PRESC=4, BLANK_GAP=1 (20-cycle frame).
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    display_scan_ctrl_if #(.N_DIG(4)) bus ();

    display_scan_ctrl #(.N_DIG(4), .PRESC(4), .BLANK_GAP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       ack;
    } exp_t;

    typedef struct packed {
        logic [15:0]      digits;
        logic             lz;
        logic [3:0][3:0]  an_s;   // expected anodes per slot (slot k = digit k)
        logic [3:0][6:0]  seg_s;  // expected segments per slot
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[6];
    vec_t v1234, v5678, v4321;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input vec_t v, input bit ack_first);
        exp_t e;
        for (int j = 0; j < 20; j++) begin
            e.an  = (j % 5 == 0) ? 4'hF : v.an_s[j / 5];
            e.seg = v.seg_s[j / 5];
            e.fd  = (j == 19);
            e.ack = ack_first && (j == 0);
            sbq.push_back(e);
        end
    endtask

    task automatic push_idle(input logic [6:0] seg0, input bit ack);
        exp_t e;
        e.an  = 4'hF;
        e.seg = seg0;
        e.fd  = 1'b0;
        e.ack = ack;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: no expectation queued at %0t", $time);
        end else begin
            e = sbq.pop_front();
            chk("an",         16'(bus.an),         16'(e.an));
            chk("seg",        16'(bus.seg),        16'(e.seg));
            chk("frame_done", 16'(bus.frame_done), 16'(e.fd));
            chk("load_ack",   16'(bus.load_ack),   16'(e.ack));
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0070, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {7'h40, 7'h40, 7'h78, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[3] = '{16'h1A23, 1'b0, {4'b0111, 4'b1111, 4'b1101, 4'b1110}, {7'h79, 7'h7F, 7'h24, 7'h30}};
        vecs[4] = '{16'h0070, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h40, 7'h40, 7'h78, 7'h40}};
        vecs[5] = '{16'h0905, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {7'h40, 7'h10, 7'h40, 7'h12}};
        v1234   = vecs[0];
        v5678   = '{16'h5678, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h12, 7'h02, 7'h78, 7'h00}};
        v4321   = '{16'h4321, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h19, 7'h30, 7'h24, 7'h79}};

        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.lz_blank  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",   16'(bus.an),         16'hF);
        chk("rst_ack",  16'(bus.load_ack),   16'h0);
        chk("rst_fd",   16'(bus.frame_done), 16'h0);
        chk("rst_seg",  16'(bus.seg),        16'h40);
        rst_n = 1'b1;
        push_idle(7'h40, 1'b0);
        push_idle(7'h40, 1'b0);
        step();
        step();

        // Table: load in IDLE, scan one full frame, return to IDLE
        for (int i = 0; i < 6; i++) begin
            bus.digits_in = vecs[i].digits;
            bus.lz_blank  = vecs[i].lz;
            bus.load      = 1'b1;
            push_idle(vecs[i].seg_s[0], 1'b1);
            step();
            bus.load = 1'b0;
            bus.en   = 1'b1;
            push_frame(vecs[i], 1'b0);
            repeat (20) step();
            bus.en = 1'b0;
            push_idle(vecs[i].seg_s[0], 1'b0);
            step();
        end

        // Mid-frame loads: newest pending wins at frame end; load on commit cycle goes direct
        bus.lz_blank  = 1'b0;
        bus.digits_in = 16'h1234;
        bus.load      = 1'b1;
        push_idle(v1234.seg_s[0], 1'b1);
        step();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        push_frame(v1234, 1'b0);
        push_frame(v5678, 1'b1);
        push_frame(v4321, 1'b1);
        for (int c = 0; c < 60; c++) begin
            step();
            bus.load = 1'b0;
            if (c == 3) begin
                bus.digits_in = 16'h9999;
                bus.load      = 1'b1;
            end
            if (c == 6) begin
                bus.digits_in = 16'h5678;
                bus.load      = 1'b1;
            end
            if (c == 39) begin
                bus.digits_in = 16'h4321;
                bus.load      = 1'b1;
            end
        end
        bus.load = 1'b0;
        bus.en   = 1'b0;
        push_idle(v4321.seg_s[0], 1'b0);
        step();

        // en dropped mid-SHOW: dark next cycle, scan restarts at digit 0
        bus.en = 1'b1;
        push_frame(v4321, 1'b0);
        repeat (8) step();
        bus.en = 1'b0;
        sbq.delete();
        repeat (3) push_idle(v4321.seg_s[0], 1'b0);
        repeat (3) step();
        bus.en = 1'b1;
        push_frame(v4321, 1'b0);
        repeat (20) step();

        // Async reset mid-SHOW, checked before any clock edge
        push_frame(v4321, 1'b0);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_an",  16'(bus.an),         16'hF);
        chk("arst_ack", 16'(bus.load_ack),   16'h0);
        chk("arst_fd",  16'(bus.frame_done), 16'h0);
        chk("arst_seg", 16'(bus.seg),        16'h40);
        sbq.delete();
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_idle(7'h40, 1'b0);
        step();

        chk("sb_drain", 16'(sbq.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
